jtkiwi_shr_bridge: RTL and testbench
====================================

// Module: jtkiwi_shr_bridge
// PURPOSE
//  Sub (sound) CPU side of the main/sub shared-RAM link. Decodes the sub Z80 window onto the 8kB
//  communication RAM, drives shr_cs/shr_addr/shr_din/sub_rnw into the main CPU block's
//  first-come-first-served arbiter, and stalls the sub Z80 (dev_busy) until the grant is
//  inferred. Read data is captured into a holding register. Sits between the sub Z80 core
//  (jtframe_z80_devwait) and the main CPU block's shared-RAM port.
// PARAMETERS
//  WIN     3'b110  sub CPU A[15:13] value selecting the shared RAM (C000-DFFF)
//  SETTLE  2       consecutive clk samples of mshramen==0 needed to infer sub grant (>=2)
//  STW     8       width of the stall counters (saturating)
// PORTS
//  rst        in   1   async reset, active-high
//  clk        in   1   system clock
//  snd_rstn   in   1   sub CPU reset from main bank latch, active-low, synchronous abort
//  A          in   16  sub Z80 address
//  mreq_n     in   1   sub Z80 memory request
//  rfsh_n     in   1   sub Z80 refresh, refresh cycles never start an access
//  wr_n       in   1   sub Z80 write strobe
//  cpu_dout   in   8   sub Z80 write data
//  mshramen   in   1   main CPU owns the shared RAM
//  shr_dout   in   8   shared RAM read port (registered, 1 clk latency from address)
//  shr_cs     out  1   request/hold of shared RAM toward arbiter
//  shr_addr   out  13  shared RAM address, A[12:0] latched at request
//  shr_din    out  8   write data latched at request
//  sub_rnw    out  1   1=read, 0=write, latched at request
//  dev_busy   out  1   stall to sub Z80 wrapper, high while access not complete
//  shr_q      out  8   captured read data, fed to sub Z80 din mux
//  stall_cur  out  STW clk cycles spent in REQ for current/last access
//  stall_max  out  STW worst stall_cur since reset
// BEHAVIOUR
//  - Reset (rst or snd_rstn==0): state IDLE; shr_cs=0, dev_busy=0, sub_rnw=1, shr_addr=0,
//    shr_din=0, shr_q=0, stall_cur=0; stall_max cleared by rst only (kept through snd_rstn).
//  - hit = !mreq_n && rfsh_n && A[15:13]==WIN, combinational; dev_busy = (hit && state==IDLE)
//    || state==REQ || state==CAP, so the Z80 stalls in the same cycle the access appears.
//  - IDLE: on hit, latch A[12:0], cpu_dout, wr_n -> shr_addr/shr_din/sub_rnw, shr_cs<=1,
//    clear sample count and stall_cur; go REQ.
//  - REQ: shr_cs held; each clk, mshramen==0 increments sample count, mshramen==1 resets it to 0;
//    stall_cur increments (saturate at all-ones). Count reaching SETTLE -> CAP. Rationale: arbiter
//    sets sshramen on the edge where it sees shr_cs && !mshramen && !ram_cs; SETTLE
//    consecutive lows guarantee sshramen is set and main is locked out.
//  - CAP: one clk; write already committed (we1 active while granted); for reads
//    shr_q<=shr_dout. stall_max<=max(stall_max,stall_cur). Go HOLD, dev_busy drops.
//  - HOLD: shr_cs stays 1 (keeps main locked out, shr_q stable) until mreq_n==1, then
//    shr_cs<=0, go IDLE. A new hit is not accepted until after one IDLE cycle.
//  - Address/data/rnw outputs never change while shr_cs==1.
//  - snd_rstn low in any state: next clk IDLE, shr_cs=0 (arbiter releases sshramen), no
//    further write strobe; partial write of one cycle is permitted.
//  - Accesses outside WIN and refresh cycles: no state change, dev_busy=0.
//  - Write latency with mshramen idle: hit at edge 0 -> IDLE->REQ at 1, CAP at 1+SETTLE, busy
//    low after 2+SETTLE (4 clk for SETTLE=2). Same for reads.
// TESTING
//  - Read C123, mshramen=0, RAM[0123]=5A -> shr_addr=0123, sub_rnw=1, dev_busy 4 clk, shr_q=5A,
//    stall_cur=2.
//  - Write DFFF<-A5, mshramen=0 -> shr_addr=1FFF, shr_din=A5, sub_rnw=0; RAM[1FFF]=A5 after release.
//  - Read with mshramen high 10 clk then low -> dev_busy high until 2 clk after fall, stall_cur=12,
//    stall_max=12; a later uncontended access leaves stall_max=12.
//  - mshramen pulsing 1,0,1,0 -> count never reaches 2, stays REQ; steady low -> completes.
//  - snd_rstn low during REQ -> shr_cs=0, dev_busy=0 next clk, no RAM write; stall_max retained.
//  - Refresh with A=C000, and access at A=E000 -> shr_cs stays 0, dev_busy stays 0.

Source files
------------

// File: rtl/jtkiwi_shr_bridge.sv
// jtkiwi_shr_bridge: sub Z80 window onto the shared communication RAM, with grant inference and stall
module jtkiwi_shr_bridge #(
    parameter logic [2:0] WIN    = 3'b110,
    parameter int         SETTLE = 2,
    parameter int         STW    = 8
)(
    input  logic           rst,
    input  logic           clk,
    input  logic           snd_rstn,
    input  logic [15:0]    A,
    input  logic           mreq_n,
    input  logic           rfsh_n,
    input  logic           wr_n,
    input  logic [7:0]     cpu_dout,
    input  logic           mshramen,
    input  logic [7:0]     shr_dout,
    output logic           shr_cs,
    output logic [12:0]    shr_addr,
    output logic [7:0]     shr_din,
    output logic           sub_rnw,
    output logic           dev_busy,
    output logic [7:0]     shr_q,
    output logic [STW-1:0] stall_cur,
    output logic [STW-1:0] stall_max
);
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, REQ, CAP, HOLD} state_t;

    state_t        st;
    logic [CW-1:0] cnt;
    logic          hit;

    // decode the shared window and stall the Z80 from the very cycle the access shows up
    always_comb begin
        hit      = !mreq_n && rfsh_n && A[15:13] == WIN;
        dev_busy = snd_rstn && ((hit && st == IDLE) || st == REQ || st == CAP);
    end

    // request, wait for consecutive main-idle samples, capture, then hold until the cycle ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            cnt       <= '0;
            shr_cs    <= 1'b0;
            shr_addr  <= '0;
            shr_din   <= '0;
            sub_rnw   <= 1'b1;
            shr_q     <= '0;
            stall_cur <= '0;
            stall_max <= '0;
        end else if (!snd_rstn) begin
            st        <= IDLE;
            cnt       <= '0;
            shr_cs    <= 1'b0;
            shr_addr  <= '0;
            shr_din   <= '0;
            sub_rnw   <= 1'b1;
            shr_q     <= '0;
            stall_cur <= '0;
        end else begin
            case (st)
                IDLE: if (hit) begin
                    shr_addr  <= A[12:0];
                    shr_din   <= cpu_dout;
                    sub_rnw   <= wr_n;
                    shr_cs    <= 1'b1;
                    cnt       <= '0;
                    stall_cur <= '0;
                    st        <= REQ;
                end
                REQ: begin
                    stall_cur <= &stall_cur ? stall_cur : stall_cur + 1'b1;
                    cnt       <= mshramen ? '0 : cnt + 1'b1;
                    if (!mshramen && cnt == LAST) st <= CAP;
                end
                CAP: begin
                    if (sub_rnw) shr_q <= shr_dout;
                    if (stall_cur > stall_max) stall_max <= stall_cur;
                    st <= HOLD;
                end
                HOLD: if (mreq_n) begin
                    shr_cs <= 1'b0;
                    st     <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtkiwi_shr_bridge.sv
// tb_jtkiwi_shr_bridge: randomized checks of the sub-side shared RAM bridge against a transaction model
module tb_jtkiwi_shr_bridge;
    localparam int SETTLE = 2;
    localparam int STW    = 8;

    logic           clk = 1'b0, rst = 1'b1, snd_rstn = 1'b1;
    logic [15:0]    addr = 16'h0;
    logic           mreq_n = 1'b1, rfsh_n = 1'b1, wr_n = 1'b1, mshramen = 1'b0;
    logic [7:0]     cpu_dout = 8'h0, shr_dout;
    logic           shr_cs, sub_rnw, dev_busy;
    logic [12:0]    shr_addr;
    logic [7:0]     shr_din, shr_q;
    logic [STW-1:0] stall_cur, stall_max;

    logic [7:0]  ram [8192] = '{default: 8'h00};
    logic [7:0]  mem [8192] = '{default: 8'h00};
    logic        sshr = 1'b0;
    logic        poke_en = 1'b0;
    logic [12:0] poke_a = 13'h0;
    logic [7:0]  poke_d = 8'h0;

    int          tests = 0, fails = 0, exp_max = 0;
    logic [7:0]  exp_q = 8'h0;

    jtkiwi_shr_bridge #(.WIN(3'b110), .SETTLE(SETTLE), .STW(STW)) dut (
        .rst(rst), .clk(clk), .snd_rstn(snd_rstn), .A(addr), .mreq_n(mreq_n), .rfsh_n(rfsh_n),
        .wr_n(wr_n), .cpu_dout(cpu_dout), .mshramen(mshramen), .shr_dout(shr_dout),
        .shr_cs(shr_cs), .shr_addr(shr_addr), .shr_din(shr_din), .sub_rnw(sub_rnw),
        .dev_busy(dev_busy), .shr_q(shr_q), .stall_cur(stall_cur), .stall_max(stall_max)
    );

    always #5 clk = ~clk;

    // shared RAM with registered read and a simple first-come arbiter for the sub side
    always @(posedge clk) begin
        shr_dout <= ram[shr_addr];
        if (sshr && shr_cs && !sub_rnw) ram[shr_addr] <= shr_din;
        if (poke_en) ram[poke_a] <= poke_d;
        if (!shr_cs) sshr <= 1'b0;
        else if (!mshramen) sshr <= 1'b1;
    end

    function automatic logic msh_at(input int n, input int hi, input logic alt);
        return n <= hi + 1 ? (alt ? (n % 2 == 0) : 1'b1) : 1'b0;
    endfunction

    // drives one Z80 access; returns clocks stalled and the stall predicted by the grant rule
    task automatic run_access(input logic [15:0] a, input logic wr, input logic [7:0] d,
                              input int hi, input logic alt, output int busy_n, output int exp_stall);
        int run;
        run = 0;
        exp_stall = 0;
        for (int n = 2; n < 1000; n++) begin
            exp_stall++;
            run = msh_at(n, hi, alt) ? 0 : run + 1;
            if (run == SETTLE) break;
        end
        addr = a; wr_n = ~wr; cpu_dout = d; rfsh_n = 1'b1; mreq_n = 1'b0;
        mshramen = msh_at(1, hi, alt);
        busy_n = 0;
        #1;
        while (dev_busy && busy_n < 300) begin
            @(posedge clk); #1;
            busy_n++;
            mshramen = msh_at(busy_n + 1, hi, alt);
        end
        mshramen = 1'b0;
    endtask

    task automatic release_bus();
        mreq_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({shr_cs, dev_busy, sub_rnw, shr_addr, shr_din, shr_q, stall_cur, stall_max} !== {3'b001, 13'h0, 8'h0, 8'h0, 8'h0, 8'h0}) begin
            fails++;
            $display("FAIL reset_outputs: got %h exp %h", {shr_cs, dev_busy, sub_rnw, shr_addr, shr_din, shr_q, stall_cur, stall_max}, {3'b001, 45'h0});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (shr_cs !== 1'b0) begin fails++; $display("FAIL reset_release_cs: got %b exp 0", shr_cs); end
    endtask

    task automatic test_read_c123();
        int bn, es;
        poke_a = 13'h0123; poke_d = 8'h5A; poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
        mem[13'h0123] = 8'h5A;
        run_access(16'hC123, 1'b0, 8'h33, 0, 1'b0, bn, es);
        exp_q = 8'h5A;
        if (es > exp_max) exp_max = es;
        tests++; if (bn !== 4) begin fails++; $display("FAIL read_busy_clks: got %0d exp 4", bn); end
        tests++; if (stall_cur !== 8'd2) begin fails++; $display("FAIL read_stall_cur: got %0d exp 2", stall_cur); end
        tests++; if (shr_q !== 8'h5A) begin fails++; $display("FAIL read_shr_q: got %h exp 5a", shr_q); end
        tests++; if ({shr_cs, sub_rnw, shr_addr} !== {2'b11, 13'h0123}) begin fails++; $display("FAIL read_hold_addr: got cs=%b rnw=%b addr=%h exp cs=1 rnw=1 addr=0123", shr_cs, sub_rnw, shr_addr); end
        release_bus();
        tests++; if ({shr_cs, dev_busy} !== 2'b00) begin fails++; $display("FAIL read_release: got cs=%b busy=%b exp 0 0", shr_cs, dev_busy); end
    endtask

    task automatic test_write_dfff();
        int bn, es;
        run_access(16'hDFFF, 1'b1, 8'hA5, 0, 1'b0, bn, es);
        mem[13'h1FFF] = 8'hA5;
        if (es > exp_max) exp_max = es;
        tests++; if (bn !== 4) begin fails++; $display("FAIL write_busy_clks: got %0d exp 4", bn); end
        tests++; if ({shr_addr, shr_din, sub_rnw} !== {13'h1FFF, 8'hA5, 1'b0}) begin fails++; $display("FAIL write_latch: got addr=%h din=%h rnw=%b exp 1fff a5 0", shr_addr, shr_din, sub_rnw); end
        release_bus();
        @(posedge clk); #1;
        tests++; if (ram[13'h1FFF] !== 8'hA5) begin fails++; $display("FAIL write_ram: got %h exp a5", ram[13'h1FFF]); end
    endtask

    task automatic test_contended();
        int bn, es;
        run_access(16'hC010, 1'b0, 8'h00, 10, 1'b0, bn, es);
        exp_q = mem[13'h0010];
        if (es > exp_max) exp_max = es;
        tests++; if (bn !== 14 || bn !== es + 2) begin fails++; $display("FAIL contended_busy: got %0d exp 14", bn); end
        tests++; if (stall_cur !== 8'd12) begin fails++; $display("FAIL contended_stall_cur: got %0d exp 12", stall_cur); end
        tests++; if (stall_max !== 8'd12) begin fails++; $display("FAIL contended_stall_max: got %0d exp 12", stall_max); end
        release_bus();
        run_access(16'hC011, 1'b0, 8'h00, 0, 1'b0, bn, es);
        exp_q = mem[13'h0011];
        tests++; if ({stall_cur, stall_max} !== {8'd2, 8'd12}) begin fails++; $display("FAIL uncontended_keep_max: got cur=%0d max=%0d exp 2 12", stall_cur, stall_max); end
        release_bus();
    endtask

    task automatic test_pulsing();
        int bn, es;
        run_access(16'hC200, 1'b1, 8'h3C, 8, 1'b1, bn, es);
        mem[13'h0200] = 8'h3C;
        if (es > exp_max) exp_max = es;
        tests++; if (bn !== es + 2 || es !== 9) begin fails++; $display("FAIL pulsing_busy: got %0d exp %0d", bn, es + 2); end
        tests++; if (stall_cur !== 8'(es)) begin fails++; $display("FAIL pulsing_stall_cur: got %0d exp %0d", stall_cur, es); end
        release_bus();
    endtask

    task automatic test_abort();
        addr = 16'hC456; wr_n = 1'b0; cpu_dout = 8'h77; rfsh_n = 1'b1; mreq_n = 1'b0; mshramen = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        addr = 16'hC999; cpu_dout = 8'h00; wr_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if ({shr_cs, dev_busy, shr_addr, shr_din, sub_rnw} !== {2'b11, 13'h0456, 8'h77, 1'b0}) begin fails++; $display("FAIL abort_req_stable: got cs=%b busy=%b addr=%h din=%h rnw=%b exp 1 1 0456 77 0", shr_cs, dev_busy, shr_addr, shr_din, sub_rnw); end
        snd_rstn = 1'b0;
        @(posedge clk); #1;
        exp_q = 8'h00;
        tests++; if ({shr_cs, dev_busy, stall_cur, shr_q} !== {2'b00, 8'h0, 8'h0}) begin fails++; $display("FAIL abort_outputs: got cs=%b busy=%b cur=%0d q=%h exp 0 0 0 00", shr_cs, dev_busy, stall_cur, shr_q); end
        tests++; if (stall_max !== 8'(exp_max)) begin fails++; $display("FAIL abort_keep_max: got %0d exp %0d", stall_max, exp_max); end
        snd_rstn = 1'b1; mreq_n = 1'b1; mshramen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (ram[13'h0456] !== mem[13'h0456]) begin fails++; $display("FAIL abort_no_write: got %h exp %h", ram[13'h0456], mem[13'h0456]); end
    endtask

    task automatic test_ignore();
        logic seen;
        seen = 1'b0;
        addr = 16'hC000; rfsh_n = 1'b0; mreq_n = 1'b0;
        for (int i = 0; i < 4; i++) begin #1; seen |= shr_cs | dev_busy; @(posedge clk); #1; seen |= shr_cs | dev_busy; end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL refresh_ignored: got activity=%b exp 0", seen); end
        seen = 1'b0;
        addr = 16'hE000; rfsh_n = 1'b1;
        for (int i = 0; i < 4; i++) begin #1; seen |= shr_cs | dev_busy; @(posedge clk); #1; seen |= shr_cs | dev_busy; end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL outside_window_ignored: got activity=%b exp 0", seen); end
        mreq_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int bn, es, hi;
        logic [15:0] a;
        logic [7:0] d;
        logic wr, alt;
        for (int i = 0; i < 24; i++) begin
            a   = {3'b110, 13'($urandom)};
            d   = 8'($urandom);
            wr  = 1'($urandom);
            alt = 1'($urandom);
            hi  = $urandom_range(0, 6);
            if (i % 3 == 2) a[12:0] = 13'h0200 + 13'(i % 4);
            run_access(a, wr, d, hi, alt, bn, es);
            if (wr) mem[a[12:0]] = d;
            else exp_q = mem[a[12:0]];
            if (es > exp_max) exp_max = es;
            tests++; if (bn !== es + 2) begin fails++; $display("FAIL rnd%0d_busy: got %0d exp %0d", i, bn, es + 2); end
            tests++; if ({stall_cur, stall_max} !== {8'(es), 8'(exp_max)}) begin fails++; $display("FAIL rnd%0d_stall: got cur=%0d max=%0d exp %0d %0d", i, stall_cur, stall_max, es, exp_max); end
            tests++; if ({shr_cs, shr_addr, shr_din, sub_rnw} !== {1'b1, a[12:0], d, ~wr}) begin fails++; $display("FAIL rnd%0d_latch: got cs=%b addr=%h din=%h rnw=%b exp 1 %h %h %b", i, shr_cs, shr_addr, shr_din, sub_rnw, a[12:0], d, ~wr); end
            tests++; if (shr_q !== exp_q) begin fails++; $display("FAIL rnd%0d_shr_q: got %h exp %h", i, shr_q, exp_q); end
            release_bus();
            tests++; if (shr_cs !== 1'b0) begin fails++; $display("FAIL rnd%0d_release: got %b exp 0", i, shr_cs); end
        end
    endtask

    initial begin
        test_reset();
        test_read_c123();
        test_write_dfff();
        test_contended();
        test_pulsing();
        test_abort();
        test_ignore();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
